// File: rtl/pt_frame_seq.sv
// Frame sequencer feeding the PT2262 code-bit stage: latches one frame of
// tri-state code words and replays it, symbol by symbol, REPEATS times.
module pt_frame_seq #(
   parameter int NTRITS  = 12,
   parameter int REPEATS = 4,
   parameter int IDX_W   = 4,
   parameter int REP_W   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2*NTRITS-1:0]   frame_data,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   output logic [1:0]            sym,
   output logic                  sym_valid,
   input  logic                  sym_ready,
   output logic                  busy,
   output logic                  frame_done
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      SYNC
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTRITS - 1);
   localparam logic [REP_W-1:0] LAST_REP = REP_W'(REPEATS - 1);
   localparam logic [1:0]       SYM_F    = 2'b10;
   localparam logic [1:0]       SYM_SYNC = 2'b11;

   state_t                state, state_n;
   logic [IDX_W-1:0]      idx, idx_n, idx_inc;
   logic [REP_W-1:0]      rep, rep_n;
   logic [2*NTRITS-1:0]   latch, latch_n;
   logic [1:0]            sym_n;
   logic                  sym_valid_n, busy_n, frame_ready_n, frame_done_n;
   logic                  consume;

   // Trit 0 sits at the MSBs; the unused code 11 is sent as F so that a SYNC
   // can never appear inside the data part of a frame.
   function automatic logic [1:0] trit_at(input logic [2*NTRITS-1:0] data,
                                          input logic [IDX_W-1:0]    i);
      logic [1:0] code;
      code = 2'b00;
      for (int t = 0; t < NTRITS; t++) begin
         if (i == IDX_W'(t)) code = data[2*(NTRITS-1-t) +: 2];
      end
      return (code == SYM_SYNC) ? SYM_F : code;
   endfunction

   // Next-state logic also computes the next value of every output, so all
   // outputs leave the block straight from flops.
   always_comb begin
      state_n       = state;
      idx_n         = idx;
      rep_n         = rep;
      latch_n       = latch;
      sym_n         = sym;
      sym_valid_n   = sym_valid;
      busy_n        = busy;
      frame_ready_n = frame_ready;
      frame_done_n  = 1'b0;
      consume       = sym_valid && sym_ready;
      idx_inc       = idx + IDX_W'(1);

      case (state)
         IDLE: begin
            if (frame_valid && frame_ready) begin
               latch_n       = frame_data;
               idx_n         = '0;
               rep_n         = '0;
               state_n       = DATA;
               sym_n         = trit_at(frame_data, '0);
               sym_valid_n   = 1'b1;
               busy_n        = 1'b1;
               frame_ready_n = 1'b0;
            end
         end

         DATA: begin
            if (consume) begin
               if (idx != LAST_IDX) begin
                  idx_n = idx_inc;
                  sym_n = trit_at(latch, idx_inc);
               end else begin
                  state_n = SYNC;
                  sym_n   = SYM_SYNC;
               end
            end
         end

         SYNC: begin
            if (consume) begin
               if (rep != LAST_REP) begin
                  rep_n   = rep + REP_W'(1);
                  idx_n   = '0;
                  state_n = DATA;
                  sym_n   = trit_at(latch, '0);
               end else begin
                  state_n       = IDLE;
                  sym_n         = 2'b00;
                  sym_valid_n   = 1'b0;
                  busy_n        = 1'b0;
                  frame_done_n  = 1'b1;
                  frame_ready_n = 1'b1;
               end
            end
         end

         default: begin
            state_n       = IDLE;
            sym_n         = 2'b00;
            sym_valid_n   = 1'b0;
            busy_n        = 1'b0;
            frame_ready_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         rep         <= '0;
         latch       <= '0;
         sym         <= 2'b00;
         sym_valid   <= 1'b0;
         busy        <= 1'b0;
         frame_ready <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         rep         <= rep_n;
         latch       <= latch_n;
         sym         <= sym_n;
         sym_valid   <= sym_valid_n;
         busy        <= busy_n;
         frame_ready <= frame_ready_n;
         frame_done  <= frame_done_n;
      end
   end

endmodule

// File: tb/tb_pt_frame_seq.sv
// Directed bench for pt_frame_seq: a 12-trit/4-repeat instance driven from a
// vector table plus hand sequences, and a 1-trit/1-repeat instance.
module tb_pt_frame_seq;

   logic        clk = 1'b0;
   logic        reset;

   logic [23:0] frame_data;
   logic        frame_valid, frame_ready;
   logic [1:0]  sym;
   logic        sym_valid, sym_ready, busy, frame_done;

   logic [1:0]  frame_data1;
   logic        frame_valid1, frame_ready1;
   logic [1:0]  sym1;
   logic        sym_valid1, sym_ready1, busy1, frame_done1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pt_frame_seq #(.NTRITS(12), .REPEATS(4), .IDX_W(4), .REP_W(3)) dut (
      .clk(clk), .reset(reset),
      .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .sym(sym), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .busy(busy), .frame_done(frame_done)
   );

   pt_frame_seq #(.NTRITS(1), .REPEATS(1), .IDX_W(1), .REP_W(1)) dut1 (
      .clk(clk), .reset(reset),
      .frame_data(frame_data1), .frame_valid(frame_valid1), .frame_ready(frame_ready1),
      .sym(sym1), .sym_valid(sym_valid1), .sym_ready(sym_ready1),
      .busy(busy1), .frame_done(frame_done1)
   );

   typedef struct {
      logic [23:0] data;
      logic [23:0] exp_trits;
      int          stall_at;
      int          stall_len;
      int          abort_at;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Walks one accepted request symbol by symbol; ends on the frame_done cycle
   // (or right after the reset when abort_at is reached).
   task automatic runSymbols(input logic [23:0] exp_trits, input int stall_at,
                             input int stall_len, input int abort_at);
      logic [1:0] exp_sym;
      int         syncs;
      syncs = 0;
      for (int s = 0; s < 52; s++) begin
         exp_sym = (s % 13 == 12) ? 2'b11 : exp_trits[2*(11 - (s % 13)) +: 2];
         if (s == abort_at) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            checkOutput("abort_sym_valid", 32'(sym_valid), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_frame_ready", 32'(frame_ready), 32'd1);
            checkOutput("abort_frame_done", 32'(frame_done), 32'd0);
            for (int j = 0; j < 3; j++) begin
               step();
               checkOutput("abort_no_done", 32'(frame_done), 32'd0);
               checkOutput("abort_idle_valid", 32'(sym_valid), 32'd0);
            end
            return;
         end
         if (s == stall_at) begin
            sym_ready = 1'b0;
            for (int j = 0; j < stall_len; j++) begin
               checkOutput("stall_sym", 32'(sym), 32'(exp_sym));
               checkOutput("stall_valid", 32'(sym_valid), 32'd1);
               step();
            end
         end
         checkOutput("sym", 32'(sym), 32'(exp_sym));
         checkOutput("sym_valid", 32'(sym_valid), 32'd1);
         checkOutput("busy", 32'(busy), 32'd1);
         checkOutput("frame_ready_busy", 32'(frame_ready), 32'd0);
         checkOutput("frame_done_early", 32'(frame_done), 32'd0);
         if (sym_valid && sym == 2'b11) syncs++;
         frame_data = 24'($urandom);
         sym_ready  = 1'b1;
         step();
      end
      checkOutput("done_pulse", 32'(frame_done), 32'd1);
      checkOutput("done_sym_valid", 32'(sym_valid), 32'd0);
      checkOutput("done_busy", 32'(busy), 32'd0);
      checkOutput("done_frame_ready", 32'(frame_ready), 32'd1);
      checkOutput("sync_count", 32'(syncs), 32'd4);
   endtask

   task automatic applyStimulus(input vec_t v);
      checkOutput("frame_ready_idle", 32'(frame_ready), 32'd1);
      frame_data  = v.data;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      runSymbols(v.exp_trits, v.stall_at, v.stall_len, v.abort_at);
      if (v.abort_at < 0) begin
         step();
         checkOutput("done_one_cycle", 32'(frame_done), 32'd0);
      end
   endtask

   initial begin
      // trits listed trit 0 first; 00=0 01=1 10=F 11=illegal
      vecs[0] = '{24'b00_01_10_00_00_01_01_10_10_00_01_00,
                  24'b00_01_10_00_00_01_01_10_10_00_01_00, -1, 0, -1};
      vecs[1] = '{24'b00_01_10_00_00_01_01_10_10_00_01_00,
                  24'b00_01_10_00_00_01_01_10_10_00_01_00, 6, 5, -1};
      vecs[2] = '{24'b01_00_10_11_01_01_00_00_10_01_00_10,
                  24'b01_00_10_10_01_01_00_00_10_01_00_10, -1, 0, -1};
      vecs[3] = '{24'hFFFFFF, 24'hAAAAAA, 12, 3, -1};
      vecs[4] = '{24'b00_01_10_00_00_01_01_10_10_00_01_00,
                  24'b00_01_10_00_00_01_01_10_10_00_01_00, -1, 0, 31};
      vecs[5] = '{24'b10_00_01_10_01_00_10_00_01_01_10_00,
                  24'b10_00_01_10_01_00_10_00_01_01_10_00, 51, 2, -1};

      reset        = 1'b1;
      frame_data   = '0;
      frame_valid  = 1'b0;
      sym_ready    = 1'b1;
      frame_data1  = '0;
      frame_valid1 = 1'b0;
      sym_ready1   = 1'b0;
      step();
      step();
      checkOutput("rst_frame_ready", 32'(frame_ready), 32'd1);
      checkOutput("rst_sym", 32'(sym), 32'd0);
      checkOutput("rst_sym_valid", 32'(sym_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      reset = 1'b0;
      step();
      checkOutput("idle_ready_ignored", 32'(sym_valid), 32'd0);

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // frame_valid held high across a whole request: the next frame is
      // taken on the frame_done edge
      frame_data  = 24'b00_01_10_00_00_01_01_10_10_00_01_00;
      frame_valid = 1'b1;
      step();
      runSymbols(24'b00_01_10_00_00_01_01_10_10_00_01_00, -1, 0, -1);
      frame_data = 24'b01_00_10_11_01_01_00_00_10_01_00_10;
      step();
      checkOutput("b2b_sym_valid", 32'(sym_valid), 32'd1);
      checkOutput("b2b_busy", 32'(busy), 32'd1);
      checkOutput("b2b_done_cleared", 32'(frame_done), 32'd0);
      runSymbols(24'b01_00_10_10_01_01_00_00_10_01_00_10, -1, 0, -1);
      frame_valid = 1'b0;
      step();
      checkOutput("b2b_end_idle", 32'(sym_valid), 32'd0);
      checkOutput("b2b_end_done", 32'(frame_done), 32'd0);

      // single-trit, single-repeat instance
      for (int k = 0; k < 2; k++) begin
         frame_data1  = (k == 0) ? 2'b01 : 2'b11;
         frame_valid1 = 1'b1;
         checkOutput("n1_ready", 32'(frame_ready1), 32'd1);
         step();
         frame_valid1 = 1'b0;
         sym_ready1   = 1'b1;
         checkOutput("n1_trit0", 32'(sym1), (k == 0) ? 32'h1 : 32'h2);
         checkOutput("n1_valid0", 32'(sym_valid1), 32'd1);
         checkOutput("n1_busy", 32'(busy1), 32'd1);
         step();
         checkOutput("n1_sync", 32'(sym1), 32'h3);
         checkOutput("n1_valid1", 32'(sym_valid1), 32'd1);
         checkOutput("n1_no_done", 32'(frame_done1), 32'd0);
         step();
         checkOutput("n1_done", 32'(frame_done1), 32'd1);
         checkOutput("n1_idle_valid", 32'(sym_valid1), 32'd0);
         checkOutput("n1_idle_busy", 32'(busy1), 32'd0);
         sym_ready1 = 1'b0;
         step();
         checkOutput("n1_done_pulse", 32'(frame_done1), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
